// File: rtl/alu_pkg.sv
// Shared types for the ALU control issue path: ALU codes, RV32I opcodes and the decoded entry.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_ILL = 4'b1111
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_ctrl_e   alu_ctrl;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        illegal;
  } dec_entry_t;

  // funct3 map shared by register and immediate ALU ops; 011 (unsigned compare) is unsupported.
  function automatic alu_ctrl_e f3_to_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b001:  return ALU_SLL;
      3'b101:  return ALU_SRL;
      3'b010:  return ALU_SLT;
      default: return ALU_ILL;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I instruction -> ALU control entry decoder.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_entry_t  dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  alu_ctrl_e   ctrl;
  logic        src2;
  logic        ill;
  logic [31:0] imm;

  always_comb begin
    ctrl = ALU_ADD;
    src2 = 1'b0;
    ill  = 1'b0;
    imm  = '0;
    case (opcode)
      OPC_OP: begin
        ctrl = f3_to_alu(f3);
        if (f3 == 3'b000 && f7 == F7_ALT) begin
          ctrl = ALU_SUB;
        end else if (f7 != F7_ZERO || f3 == 3'b011) begin
          ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ctrl = f3_to_alu(f3);
        src2 = 1'b1;
        imm  = imm_i;
        // Shift-immediates carry funct7 in imm[11:5]; only the logical forms are supported.
        if (f3 == 3'b011) begin
          ill = 1'b1;
        end else if ((f3 == 3'b001 || f3 == 3'b101) && f7 != F7_ZERO) begin
          ill = 1'b1;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        src2 = 1'b1;
        imm  = imm_i;
      end
      OPC_STORE: begin
        src2 = 1'b1;
        imm  = imm_s;
      end
      OPC_LUI, OPC_AUIPC: begin
        src2 = 1'b1;
        imm  = imm_u;
      end
      OPC_JAL: begin
        src2 = 1'b1;
        imm  = imm_j;
      end
      OPC_BRANCH: begin
        imm = imm_b;
        case (f3[2:1])
          2'b00:   ctrl = ALU_SUB;
          2'b10:   ctrl = ALU_SLT;
          default: ill  = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      ctrl = ALU_ILL;
      src2 = 1'b0;
      imm  = '0;
    end
  end

  assign dec_o = '{alu_ctrl: ctrl, src2_imm: src2, imm: imm, rd: instr_i[11:7], illegal: ill};

endmodule

// File: rtl/alu_ctrl_issue.sv
// Issue stage: decodes RV32I instructions into ALU controls behind a 2-entry skid buffer.
// Perf counters are built only when ALU_ISSUE_PERF_CNT_EN is defined.
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [31:0]      instr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       alu_ctrl_o,
  output logic             src2_imm_o,
  output logic [31:0]      imm_o,
  output logic [4:0]       rd_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] dec_cnt_o,
  output logic [CNT_W-1:0] ill_cnt_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  dec_entry_t dec_ent;
  dec_entry_t main_q;
  dec_entry_t main_d;
  dec_entry_t skid_q;
  dec_entry_t skid_d;
  logic       accept;
  logic       pop;

  alu_ctrl_decode u_decode (
    .instr_i (instr_i),
    .dec_o   (dec_ent)
  );

  // Ready depends only on state, so there is no combinational path from out_ready_i.
  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec_ent;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = dec_ent;
          end else if (accept) begin
            skid_d  = dec_ent;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign alu_ctrl_o = main_q.alu_ctrl;
  assign src2_imm_o = main_q.src2_imm;
  assign imm_o      = main_q.imm;
  assign rd_o       = main_q.rd;
  assign illegal_o  = main_q.illegal;

`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] dec_cnt_q;
  logic [CNT_W-1:0] dec_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q;
  logic [CNT_W-1:0] ill_cnt_d;

  // Counts every handshake, independent of flush; wraps naturally.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (accept) begin
      dec_cnt_d = dec_cnt_q + CNT_W'(1);
      if (dec_ent.illegal) begin
        ill_cnt_d = ill_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign dec_cnt_o = dec_cnt_q;
  assign ill_cnt_o = ill_cnt_q;
`else
  assign dec_cnt_o = '0;
  assign ill_cnt_o = '0;
`endif

endmodule
